// File: rtl/vlane_pkg.sv
// Shared types for the vector-lane writeback path: SEW codes, packer FSM state
// and the writeback FIFO entry. Entry fields are sized for the widest lane (64b, 8 words).
package vlane_pkg;
    localparam int VLANE_DATA_W = 64;
    localparam int VLANE_WORD_W = 3;
    localparam int VLANE_BE_W   = VLANE_DATA_W / 8;

    typedef enum logic [2:0] {
        SEW_8  = 3'd0,
        SEW_16 = 3'd1,
        SEW_32 = 3'd2,
        SEW_64 = 3'd3
    } sew_e;

    typedef enum logic {
        PK_IDLE  = 1'b0,
        PK_ACCUM = 1'b1
    } pk_state_e;

    typedef struct packed {
        logic [4:0]              addr;
        logic [VLANE_WORD_W-1:0] word;
        logic [VLANE_DATA_W-1:0] data;
        logic [VLANE_BE_W-1:0]   be;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Writeback output buffer: DEPTH-entry circular FIFO, head shown combinationally
// and forced to zero when empty so the VRF port idles at all-zero.
module wb_fifo
    import vlane_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;

    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/vrf_writeback.sv
// VRF writeback stage: packs compare-mask beats into full register words and buffers
// all writes in wb_fifo. Define VRF_WB_BYPASS_EN to let non-mask beats skip an empty FIFO.
module vrf_writeback
    import vlane_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int EXECUTION_OUTPUT = 64,
    parameter int FIFO_DEPTH       = 4,
    parameter int WORD_W           = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [EXECUTION_OUTPUT-1:0]   result_i,
    input  logic                          masked_write_back_i,
    input  logic [2:0]                    sew_i,
    input  logic [4:0]                    dst_i,
    input  logic [WORD_W-1:0]             word_i,
    input  logic                          last_i,
    output logic                          wr_en_o,
    input  logic                          wr_ready_i,
    output logic [4:0]                    wr_addr_o,
    output logic [WORD_W-1:0]             wr_word_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o,
    output logic [DATA_WIDTH/8-1:0]       wr_be_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(DATA_WIDTH) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pk_state_e             state, state_nx;
    sew_e                  sew_q, sew_eff;
    logic [4:0]            dst_q, dst_eff;
    logic [OFF_W-1:0]      off_q, off_nx, nbits, fill;
    logic [WORD_W-1:0]     mword_q, mword_nx;
    logic [DATA_WIDTH-1:0] acc_q, acc_nx, res_dw, beat_bits, acc_sum;

    logic                  accept, mask_beat, bypass, push, pop, fifo_empty;
    logic [CNT_W-1:0]      count;
    wb_entry_t             push_entry, nm_entry, head, out;

    assign ready_o   = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign accept    = valid_i && ready_o;
    assign mask_beat = accept && masked_write_back_i;

`ifdef VRF_WB_BYPASS_EN
    assign bypass = accept && !masked_write_back_i && fifo_empty && wr_ready_i;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        nm_entry      = '0;
        nm_entry.addr = dst_i;
        nm_entry.word = VLANE_WORD_W'(word_i);
        nm_entry.data = VLANE_DATA_W'(DATA_WIDTH'(result_i));
        nm_entry.be   = VLANE_BE_W'({BE_W{1'b1}});
    end

    // Mask slice: the first beat of an instruction supplies sew/dst, later beats reuse the latch.
    always_comb begin
        sew_eff   = (state == PK_IDLE) ? sew_e'(sew_i) : sew_q;
        dst_eff   = (state == PK_IDLE) ? dst_i : dst_q;
        nbits     = OFF_W'(DATA_WIDTH >> (3 + int'(sew_eff)));
        res_dw    = DATA_WIDTH'(result_i);
        beat_bits = res_dw & ~({DATA_WIDTH{1'b1}} << nbits);
        acc_sum   = acc_q | (beat_bits << off_q);
        fill      = off_q + nbits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PK_IDLE;
            off_q   <= '0;
            mword_q <= '0;
            acc_q   <= '0;
            sew_q   <= SEW_8;
            dst_q   <= '0;
        end else begin
            state   <= state_nx;
            off_q   <= off_nx;
            mword_q <= mword_nx;
            acc_q   <= acc_nx;
            if (mask_beat && state == PK_IDLE) begin
                sew_q <= sew_e'(sew_i);
                dst_q <= dst_i;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (mask_beat)
            state_nx = last_i ? PK_IDLE : PK_ACCUM;
    end

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        off_nx     = off_q;
        mword_nx   = mword_q;
        acc_nx     = acc_q;
        if (mask_beat) begin
            acc_nx = acc_sum;
            off_nx = fill;
            if (fill >= OFF_W'(DATA_WIDTH) || last_i) begin
                push            = 1'b1;
                push_entry.addr = dst_eff;
                push_entry.word = VLANE_WORD_W'(mword_q);
                push_entry.data = VLANE_DATA_W'(acc_sum);
                // Bytes touched by the fill; a full word enables every byte.
                for (int b = 0; b < BE_W; b++)
                    push_entry.be[b] = (OFF_W'(b * 8) < fill);
                acc_nx   = '0;
                off_nx   = '0;
                mword_nx = last_i ? '0 : mword_q + 1'b1;
            end
        end else if (accept && !bypass) begin
            push       = 1'b1;
            push_entry = nm_entry;
        end
    end

    assign pop = !fifo_empty && wr_ready_i;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_comb begin
        wr_en_o = !fifo_empty;
        out     = head;
        if (bypass) begin
            wr_en_o = 1'b1;
            out     = nm_entry;
        end
    end

    assign wr_addr_o = out.addr;
    assign wr_word_o = WORD_W'(out.word);
    assign wr_data_o = DATA_WIDTH'(out.data);
    assign wr_be_o   = BE_W'(out.be);
    assign count_o   = count;
endmodule

// File: tb/tb_vrf_writeback.sv
// Directed bench for vrf_writeback (DATA_WIDTH=64, bypass off): table of single-beat
// vectors plus hand sequences for mask packing, backpressure and mid-instruction reset.
module tb_vrf_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, masked_write_back_i, last_i;
    logic [63:0] result_i;
    logic [2:0]  sew_i;
    logic [4:0]  dst_i;
    logic [2:0]  word_i;
    logic        wr_en_o, wr_ready_i;
    logic [4:0]  wr_addr_o;
    logic [2:0]  wr_word_o;
    logic [63:0] wr_data_o;
    logic [7:0]  wr_be_o;
    logic [2:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vrf_writeback dut (
        .clk                 (clk),
        .rst                 (rst),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .result_i            (result_i),
        .masked_write_back_i (masked_write_back_i),
        .sew_i               (sew_i),
        .dst_i               (dst_i),
        .word_i              (word_i),
        .last_i              (last_i),
        .wr_en_o             (wr_en_o),
        .wr_ready_i          (wr_ready_i),
        .wr_addr_o           (wr_addr_o),
        .wr_word_o           (wr_word_o),
        .wr_data_o           (wr_data_o),
        .wr_be_o             (wr_be_o),
        .count_o             (count_o)
    );

    typedef struct {
        logic        m;
        logic [2:0]  sew;
        logic [4:0]  dst;
        logic [2:0]  word;
        logic [63:0] res;
        logic [4:0]  e_addr;
        logic [2:0]  e_word;
        logic [63:0] e_data;
        logic [7:0]  e_be;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One beat offered for one cycle; returns sampled #1 after the edge.
    task automatic beat(input logic m, input logic [2:0] s, input logic [4:0] d,
                        input logic [2:0] w, input logic [63:0] r, input logic l);
        valid_i = 1'b1; masked_write_back_i = m; sew_i = s; dst_i = d;
        word_i = w; result_i = r; last_i = l;
        @(posedge clk); #1;
        valid_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic chk_write(input string nm, input logic [4:0] a, input logic [2:0] w,
                             input logic [63:0] dt, input logic [7:0] be);
        chk({nm, "_en"},   64'(wr_en_o),   64'd1);
        chk({nm, "_addr"}, 64'(wr_addr_o), 64'(a));
        chk({nm, "_word"}, 64'(wr_word_o), 64'(w));
        chk({nm, "_data"}, wr_data_o,      dt);
        chk({nm, "_be"},   64'(wr_be_o),   64'(be));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic [63:0] d [5];

        vecs[0] = '{1'b0, 3'd0, 5'd3,  3'd2, 64'h0123456789ABCDEF, 5'd3,  3'd2, 64'h0123456789ABCDEF, 8'hFF};
        vecs[1] = '{1'b0, 3'd1, 5'd31, 3'd7, 64'hFFFF0000FFFF0000, 5'd31, 3'd7, 64'hFFFF0000FFFF0000, 8'hFF};
        vecs[2] = '{1'b0, 3'd3, 5'd0,  3'd0, 64'h0,                5'd0,  3'd0, 64'h0,                8'hFF};
        vecs[3] = '{1'b1, 3'd3, 5'd7,  3'd5, 64'hFFFFFFFFFFFFFFFF, 5'd7,  3'd0, 64'h1,                8'h01};
        vecs[4] = '{1'b1, 3'd1, 5'd12, 3'd3, 64'hABCD,             5'd12, 3'd0, 64'hD,                8'h01};
        vecs[5] = '{1'b1, 3'd0, 5'd20, 3'd1, 64'h1234,             5'd20, 3'd0, 64'h34,               8'h01};

        rst = 1'b1; valid_i = 1'b0; masked_write_back_i = 1'b0; sew_i = '0; dst_i = '0;
        word_i = '0; result_i = '0; last_i = 1'b0; wr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  64'(ready_o),   64'd0);
        chk("rst_wr_en",  64'(wr_en_o),   64'd0);
        chk("rst_count",  64'(count_o),   64'd0);
        chk("rst_addr",   64'(wr_addr_o), 64'd0);
        chk("rst_data",   wr_data_o,      64'd0);
        chk("rst_be",     64'(wr_be_o),   64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            beat(vecs[i].m, vecs[i].sew, vecs[i].dst, vecs[i].word, vecs[i].res, 1'b1);
            chk_write($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_word, vecs[i].e_data, vecs[i].e_be);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_drained", i), 64'(wr_en_o), 64'd0);
        end

        // Eight SEW=8 mask beats fill exactly one word.
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 3'd0, 5'd4, 3'd6, 64'hA5, i == 7);
            if (i == 6) chk("sew8_no_early_write", 64'(wr_en_o), 64'd0);
        end
        chk_write("sew8_full", 5'd4, 3'd0, 64'hA5A5A5A5A5A5A5A5, 8'hFF);
        @(posedge clk); #1;

        // SEW=32 partial fill; later beats carry different dst/sew that must be ignored.
        beat(1'b1, 3'd2, 5'd5, 3'd0, 64'h1, 1'b0);
        beat(1'b1, 3'd0, 5'd9, 3'd0, 64'h2, 1'b0);
        beat(1'b1, 3'd0, 5'd9, 3'd0, 64'h3, 1'b1);
        chk_write("sew32_partial", 5'd5, 3'd0, 64'h39, 8'h01);
        @(posedge clk); #1;

        // Nine SEW=8 beats spill into a second word.
        for (int i = 0; i < 9; i++) begin
            beat(1'b1, 3'd0, 5'd6, 3'd0, 64'hFF, i == 8);
            if (i == 7) chk_write("spill_w0", 5'd6, 3'd0, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        end
        chk_write("spill_w1", 5'd6, 3'd1, 64'hFF, 8'h01);
        @(posedge clk); #1;
        chk("spill_drained", 64'(wr_en_o), 64'd0);

        // Backpressure: fill the FIFO, stall the fifth beat, then drain in order.
        wr_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) d[i] = 64'h1000 + 64'(i * 17);
        for (int i = 0; i < 4; i++) beat(1'b0, 3'd0, 5'd1, 3'(i), d[i], 1'b0);
        chk("bp_count_full", 64'(count_o), 64'd4);
        chk("bp_ready_low",  64'(ready_o), 64'd0);
        valid_i = 1'b1; masked_write_back_i = 1'b0; dst_i = 5'd1; word_i = 3'd4; result_i = d[4];
        repeat (2) @(posedge clk);
        #1;
        chk("bp_stalled_count", 64'(count_o), 64'd4);
        chk("bp_head_hold",     wr_data_o,    d[0]);
        wr_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_write($sformatf("bp_drain%0d", i), 5'd1, 3'(i), d[i], 8'hFF);
            acc = valid_i && ready_o;
            if (i == 0) chk("bp_ready_ignores_deq", 64'(ready_o), 64'd0);
            @(posedge clk); #1;
            if (acc) valid_i = 1'b0;
        end
        chk("bp_empty_wr_en", 64'(wr_en_o), 64'd0);
        chk("bp_empty_count", 64'(count_o), 64'd0);
        chk("bp_all_accepted", 64'(valid_i), 64'd0);

        // Reset mid-accumulation discards the partial word.
        for (int i = 0; i < 3; i++) beat(1'b1, 3'd0, 5'd8, 3'd0, 64'h11, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_wr_en", 64'(wr_en_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_write", 64'(wr_en_o), 64'd0);
        chk("midrst_count",    64'(count_o), 64'd0);
        beat(1'b1, 3'd0, 5'd10, 3'd0, 64'h5A, 1'b1);
        chk_write("midrst_restart", 5'd10, 3'd0, 64'h5A, 8'h01);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
